fft_stim_player: RTL and testbench

FFT_STIM_PLAYER -- requirements
Module: fft_stim_player

---
 rtl/fft_stim_player.sv | 202 ++++++++++++++++++++
 tb/tb_fft_stim_player.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stim_player.sv
// fft_stim_player: plays a preloaded frame of signed samples into an FFT core.
// After reset it waits WAKE cycles for the FFT to come out of reset. On start it
// streams FRAMES frames of 2**N samples, with GAP idle cycles between frames.
// Define FFT_STIM_CAPTURE_EN to also capture FFT results into a readable RAM.
// In that build, done waits until every expected result has arrived.
module fft_stim_player #(
  parameter int WIDTH  = 16,
  parameter int N      = 9,
  parameter int WAKE   = 20,
  parameter int GAP    = 0,
  parameter int FRAMES = 1
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic                    ld_we,
  input  logic [N-1:0]            ld_addr,
  input  logic signed [WIDTH-1:0] ld_data,
  output logic                    fft_din_en,
  output logic signed [WIDTH-1:0] fft_din_ad,
  input  logic                    fft_dout_en,
  input  logic [N-1:0]            fft_dout_cnt,
  input  logic [WIDTH-1:0]        fft_dout_re,
  input  logic [WIDTH-1:0]        fft_dout_im,
  input  logic [N-1:0]            rd_addr,
  output logic [WIDTH-1:0]        rd_re,
  output logic [WIDTH-1:0]        rd_im
);

  localparam int DEPTH  = 1 << N;
  localparam int WAKE_W = (WAKE > 1) ? $clog2(WAKE) : 1;
  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [WAKE_W-1:0] WAKE_LAST  = WAKE_W'((WAKE > 0) ? WAKE - 1 : 0);
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [7:0]        FRAME_LAST = 8'(FRAMES - 1);

  typedef enum logic [2:0] {S_WAKE, S_IDLE, S_PLAY, S_GAP, S_FIN} state_t;

  state_t                  state_q, state_d;
  logic [WAKE_W-1:0]       wake_cnt_q, wake_cnt_d;
  logic [N-1:0]            idx_q, idx_d;
  logic [7:0]              frame_q, frame_d;
  logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    din_en_q, din_en_d;
  logic signed [WIDTH-1:0] din_ad_q, din_ad_d;
  logic                    start_acc;
  logic                    cap_full;
  logic                    ld_ok;

  logic signed [WIDTH-1:0] sample_mem [DEPTH];

  assign ld_ok = ld_we && (state_q == S_WAKE || state_q == S_IDLE);

  // Sample memory is writable only while idle and is deliberately not reset.
  always_ff @(posedge clk) begin
    if (ld_ok) sample_mem[ld_addr] <= ld_data;
  end

  // Sequencer next-state logic plus the registered FFT drive values.
  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    gap_cnt_d  = gap_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    start_acc  = 1'b0;
    din_en_d   = (state_q == S_PLAY);
    din_ad_d   = (state_q == S_PLAY) ? sample_mem[idx_q] : '0;
    case (state_q)
      S_WAKE: begin
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = S_IDLE;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (start) begin
          state_d   = S_PLAY;
          idx_d     = '0;
          frame_d   = '0;
          busy_d    = 1'b1;
          start_acc = 1'b1;
        end
      end
      S_PLAY: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == {N{1'b1}}) begin
          frame_d = frame_q + 8'd1;
          if (frame_q == FRAME_LAST) begin
            state_d = S_FIN;
          end else if (GAP > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = S_PLAY;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      S_FIN: begin
        if (cap_full) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_WAKE;
    endcase
  end

  // State, counters and outputs; reset drops everything back into WAKE.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q    <= S_WAKE;
      wake_cnt_q <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      gap_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      din_en_q   <= 1'b0;
      din_ad_q   <= '0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      gap_cnt_q  <= gap_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      din_en_q   <= din_en_d;
      din_ad_q   <= din_ad_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign fft_din_en = din_en_q;
  assign fft_din_ad = din_ad_q;

`ifdef FFT_STIM_CAPTURE_EN
  localparam int CAP_W = N + 9;
  localparam logic [CAP_W-1:0] CAP_TOTAL = CAP_W'(FRAMES * DEPTH);

  logic [2*WIDTH-1:0] cap_mem [DEPTH];
  logic [CAP_W-1:0]   cap_cnt_q, cap_cnt_d;
  logic [2*WIDTH-1:0] rd_q, rd_d;

  // Results land at the address the FFT reports, whatever state we are in.
  always_ff @(posedge clk) begin
    if (fft_dout_en) cap_mem[fft_dout_cnt] <= {fft_dout_re, fft_dout_im};
  end

  // Result counter restarts with each run and saturates at a full run's worth.
  always_comb begin
    cap_cnt_d = cap_cnt_q;
    if (start_acc) begin
      cap_cnt_d = '0;
    end else if (fft_dout_en && cap_cnt_q != CAP_TOTAL) begin
      cap_cnt_d = cap_cnt_q + 1'b1;
    end
    rd_d = cap_mem[rd_addr];
  end

  // Readback register samples the RAM before a same-edge write lands.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      cap_cnt_q <= '0;
      rd_q      <= '0;
    end else begin
      cap_cnt_q <= cap_cnt_d;
      rd_q      <= rd_d;
    end
  end

  assign cap_full = (cap_cnt_q == CAP_TOTAL);
  assign rd_re    = rd_q[2*WIDTH-1:WIDTH];
  assign rd_im    = rd_q[WIDTH-1:0];
`else
  logic unused_capture;

  assign cap_full       = 1'b1;
  assign rd_re          = '0;
  assign rd_im          = '0;
  assign unused_capture = ^{fft_dout_en, fft_dout_cnt, fft_dout_re, fft_dout_im,
                            rd_addr, start_acc};
`endif

endmodule

// File: tb/tb_fft_stim_player.sv
// Self-checking bench for fft_stim_player (N=9, WAKE=20, GAP=4, FRAMES=3).
// Expected samples and readback words are queued as stimulus is issued.
// They are popped and compared as the DUT produces them.
module tb_fft_stim_player;

  localparam int WIDTH  = 16;
  localparam int N      = 9;
  localparam int WAKE   = 20;
  localparam int GAP    = 4;
  localparam int FRAMES = 3;
  localparam int DEPTH  = 1 << N;

  logic                    clk;
  logic                    areset;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    ld_we;
  logic [N-1:0]            ld_addr;
  logic signed [WIDTH-1:0] ld_data;
  logic                    fft_din_en;
  logic signed [WIDTH-1:0] fft_din_ad;
  logic                    fft_dout_en;
  logic [N-1:0]            fft_dout_cnt;
  logic [WIDTH-1:0]        fft_dout_re;
  logic [WIDTH-1:0]        fft_dout_im;
  logic [N-1:0]            rd_addr;
  logic [WIDTH-1:0]        rd_re;
  logic [WIDTH-1:0]        rd_im;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [WIDTH-1:0]   exp_q[$];
  logic [2*WIDTH-1:0] rb_q[$];

  fft_stim_player #(
    .WIDTH(WIDTH), .N(N), .WAKE(WAKE), .GAP(GAP), .FRAMES(FRAMES)
  ) dut (
    .clk(clk), .areset(areset), .start(start), .busy(busy), .done(done),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .fft_din_en(fft_din_en), .fft_din_ad(fft_din_ad),
    .fft_dout_en(fft_dout_en), .fft_dout_cnt(fft_dout_cnt),
    .fft_dout_re(fft_dout_re), .fft_dout_im(fft_dout_im),
    .rd_addr(rd_addr), .rd_re(rd_re), .rd_im(rd_im)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used for latency measurements.
  always @(posedge clk) cyc++;

  // Absolute time limit so a stuck run still ends with a report.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired: sim time %0t exceeds limit %0d", $time, 3000000);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = a[N-1-i];
    return r;
  endfunction

  task automatic test_reset();
    areset = 1'b0; start = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    fft_dout_en = 1'b0; fft_dout_cnt = '0; fft_dout_re = '0; fft_dout_im = '0;
    rd_addr = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, fft_din_en} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_ctl got busy/done/en=%b expected 000", {busy, done, fft_din_en});
    end
    checks++;
    if (fft_din_ad !== '0) begin
      errors++;
      $display("[TB] FAIL reset_din_ad got %0d expected 0", fft_din_ad);
    end
    checks++;
    if ({rd_re, rd_im} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_rd got %h expected 0", {rd_re, rd_im});
    end
  endtask

  // Release reset and poke start during the wake window; it must be ignored.
  task automatic test_wake();
    areset = 1'b1;
    for (int c = 1; c <= WAKE + 2; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wake_busy cycle %0d got %b expected 0", c, busy);
      end
      start = (c == 5);
    end
    start = 1'b0;
  endtask

  task automatic test_load();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      ld_we = 1'b1; ld_addr = N'(i); ld_data = WIDTH'(i);
    end
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  // One full run: sample stream, frame gaps, then the completion handshake.
  task automatic test_play(input bit poke);
    int first_c, last_c, run, idle_total, budget, start_c;
    bit seen_first;
    logic [WIDTH-1:0] e;
    logic [N-1:0] a;
    exp_q.delete();
    for (int f = 0; f < FRAMES; f++)
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(WIDTH'(i));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_c = cyc;
    checks++;
    if (busy !== 1'b1 || fft_din_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_accept got busy=%b en=%b expected busy=1 en=0", busy, fft_din_en);
    end
    first_c = 0; last_c = 0; run = 0; idle_total = 0; budget = 0; seen_first = 0;
    while (exp_q.size() > 0 && budget < 4000) begin
      @(negedge clk);
      budget++;
      start = 1'b0;
      ld_we = 1'b0;
      if (fft_din_en === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if (fft_din_ad !== e) begin
          errors++;
          $display("[TB] FAIL sample got %0d expected %0d", fft_din_ad, e);
        end
        if (!seen_first) begin
          seen_first = 1;
          first_c = cyc;
          checks++;
          if (first_c != start_c + 1) begin
            errors++;
            $display("[TB] FAIL first_latency got %0d expected 1", first_c - start_c);
          end
        end else if (run > 0) begin
          checks++;
          if (run != GAP) begin
            errors++;
            $display("[TB] FAIL gap_len got %0d expected %0d", run, GAP);
          end
        end
        run = 0;
        last_c = cyc;
        if (poke && exp_q.size() == 1000) begin
          start = 1'b1; ld_we = 1'b1; ld_addr = N'(3); ld_data = WIDTH'(999);
        end
      end else begin
        checks++;
        if (fft_din_ad !== '0) begin
          errors++;
          $display("[TB] FAIL idle_din_ad got %0d expected 0", fft_din_ad);
        end
        if (seen_first) begin
          run++;
          idle_total++;
        end
      end
    end
    start = 1'b0;
    ld_we = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL play_timeout got %0d samples left expected 0", exp_q.size());
    end
    checks++;
    if (last_c - first_c + 1 != FRAMES * DEPTH + (FRAMES - 1) * GAP) begin
      errors++;
      $display("[TB] FAIL burst_span got %0d expected %0d", last_c - first_c + 1,
               FRAMES * DEPTH + (FRAMES - 1) * GAP);
    end
    checks++;
    if (idle_total != (FRAMES - 1) * GAP) begin
      errors++;
      $display("[TB] FAIL idle_total got %0d expected %0d", idle_total, (FRAMES - 1) * GAP);
    end
`ifdef FFT_STIM_CAPTURE_EN
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL fin_wait got done=%b busy=%b expected done=0 busy=1", done, busy);
      end
    end
    for (int k = 0; k < FRAMES * DEPTH; k++) begin
      @(negedge clk);
      a = bitrev(N'(k % DEPTH));
      fft_dout_en = 1'b1; fft_dout_cnt = a;
      fft_dout_re = WIDTH'(a); fft_dout_im = -WIDTH'(a);
    end
    @(negedge clk);
    fft_dout_en = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_early got %b expected 0", done);
    end
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || fft_din_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_pulse got done=%b busy=%b en=%b expected 1 0 0", done, busy, fft_din_en);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_once got %b expected 0", done);
    end
  endtask

  // Readback pipeline, including a read that collides with a capture write.
  task automatic test_readback();
    int addrs[6] = '{5, 0, 511, 256, 7, 7};
    logic [2*WIDTH-1:0] e, got;
    logic [WIDTH-1:0] er, ei;
    rb_q.delete();
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      fft_dout_en = 1'b0;
      if (rb_q.size() > 0) begin
        got = {rd_re, rd_im};
        e = rb_q.pop_front();
        checks++;
        if (got !== e) begin
          errors++;
          $display("[TB] FAIL readback step %0d got %h expected %h", i, got, e);
        end
      end
      if (i < 6) begin
        rd_addr = N'(addrs[i]);
`ifdef FFT_STIM_CAPTURE_EN
        er = WIDTH'(addrs[i]);
        ei = -er;
        e = (i == 5) ? {WIDTH'(100), WIDTH'(100)} : {er, ei};
`else
        er = '0;
        ei = '0;
        e = {er, ei};
`endif
        rb_q.push_back(e);
        if (i == 4) begin
          fft_dout_en = 1'b1; fft_dout_cnt = N'(7);
          fft_dout_re = WIDTH'(100); fft_dout_im = WIDTH'(100);
        end
      end
    end
    fft_dout_en = 1'b0;
  endtask

  // Reset mid-frame must kill the stream at once and force a fresh wake.
  task automatic test_reset_mid();
    bit found;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int b = 0; b < 1000; b++) begin
      @(negedge clk);
      if (fft_din_en === 1'b1 && fft_din_ad === WIDTH'(200)) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL reach_sample200 got not_seen expected seen");
    end
    areset = 1'b0;
    #1;
    checks++;
    if (fft_din_en !== 1'b0 || busy !== 1'b0 || fft_din_ad !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset got en=%b busy=%b ad=%0d expected 0 0 0", fft_din_en, busy, fft_din_ad);
    end
    @(negedge clk);
    test_wake();
    test_play(0);
  endtask

  initial begin
    test_reset();
    test_wake();
    test_load();
    test_play(1);
    test_readback();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
